// File: rtl/sdram_ch2_arbiter.sv
// Three-port round-robin arbiter onto one 32-bit SDRAM controller channel.
// Requests are latched per port; one transfer is in flight at a time.
module sdram_ch2_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        port0_req,
   input  logic        port0_rnw,
   input  logic [26:0] port0_addr,
   input  logic [31:0] port0_din,
   input  logic [3:0]  port0_be,
   output logic [31:0] port0_dout,
   output logic        port0_done,
   input  logic        port1_req,
   input  logic        port1_rnw,
   input  logic [26:0] port1_addr,
   input  logic [31:0] port1_din,
   input  logic [3:0]  port1_be,
   output logic [31:0] port1_dout,
   output logic        port1_done,
   input  logic        port2_req,
   input  logic        port2_rnw,
   input  logic [26:0] port2_addr,
   input  logic [31:0] port2_din,
   input  logic [3:0]  port2_be,
   output logic [31:0] port2_dout,
   output logic        port2_done,
   output logic        sdram_req,
   output logic        sdram_rnw,
   output logic [26:0] sdram_addr,
   output logic [31:0] sdram_din,
   output logic [3:0]  sdram_be,
   input  logic [31:0] sdram_dout,
   input  logic        sdram_ready,
   input  logic        pause,
   output logic        busy,
   output logic        timeout_err
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [1:0]    state, cur, last_grant, start, win;
   logic [CW-1:0] cnt;
   logic [2:0]    req_v, in_rnw, pending, accept, pend_eff;
   logic [2:0]    fin_v, done_q, lat_rnw, rnw_nxt;
   logic [26:0]   in_addr [3];
   logic [26:0]   lat_addr [3];
   logic [26:0]   addr_nxt [3];
   logic [31:0]   in_din [3];
   logic [31:0]   lat_din [3];
   logic [31:0]   din_nxt [3];
   logic [31:0]   dout_q [3];
   logic [3:0]    in_be [3];
   logic [3:0]    lat_be [3];
   logic [3:0]    be_nxt [3];
   logic          ready_hit, to_hit, fin, cnt_last;

   assign req_v      = {port2_req, port1_req, port0_req};
   assign in_rnw     = {port2_rnw, port1_rnw, port0_rnw};
   assign in_addr[0] = port0_addr;
   assign in_addr[1] = port1_addr;
   assign in_addr[2] = port2_addr;
   assign in_din[0]  = port0_din;
   assign in_din[1]  = port1_din;
   assign in_din[2]  = port2_din;
   assign in_be[0]   = port0_be;
   assign in_be[1]   = port1_be;
   assign in_be[2]   = port2_be;

   assign cnt_last  = (cnt == CW'(TIMEOUT - 1));
   assign ready_hit = (state == S_WAIT) & sdram_ready;
   assign to_hit    = (state == S_WAIT) & ~sdram_ready & cnt_last;
   assign fin       = ready_hit | to_hit;
   assign fin_v     = fin ? (3'b001 << cur) : 3'b000;

   // A port finishing this edge may re-request on the same edge.
   assign accept    = req_v & (~pending | fin_v);
   assign pend_eff  = pending | accept;
   assign start     = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;

   always_comb begin
      for (int n = 0; n < 3; n++) begin
         rnw_nxt[n]  = accept[n] ? in_rnw[n]  : lat_rnw[n];
         addr_nxt[n] = accept[n] ? in_addr[n] : lat_addr[n];
         din_nxt[n]  = accept[n] ? in_din[n]  : lat_din[n];
         be_nxt[n]   = accept[n] ? in_be[n]   : lat_be[n];
      end
   end

   // Scan from farthest to nearest so the port closest to start wins.
   always_comb begin
      logic [2:0] idx;
      win = start;
      idx = 3'd0;
      for (int k = 2; k >= 0; k--) begin
         idx = {1'b0, start} + 3'(k);
         if (idx > 3'd2) idx = idx - 3'd3;
         if (pend_eff[idx]) win = idx[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         cur         <= 2'd0;
         last_grant  <= 2'd2;
         cnt         <= '0;
         pending     <= 3'b000;
         done_q      <= 3'b000;
         timeout_err <= 1'b0;
         sdram_rnw   <= 1'b1;
         sdram_addr  <= '0;
         sdram_din   <= '0;
         sdram_be    <= '0;
         lat_rnw     <= 3'b111;
         for (int n = 0; n < 3; n++) begin
            lat_addr[n] <= '0;
            lat_din[n]  <= '0;
            lat_be[n]   <= '0;
            dout_q[n]   <= '0;
         end
      end else begin
         done_q  <= fin_v;
         pending <= (pending & ~fin_v) | accept;
         lat_rnw <= rnw_nxt;
         for (int n = 0; n < 3; n++) begin
            lat_addr[n] <= addr_nxt[n];
            lat_din[n]  <= din_nxt[n];
            lat_be[n]   <= be_nxt[n];
         end
         unique case (state)
            S_IDLE: begin
               if (!pause && |pend_eff) begin
                  state      <= S_ISSUE;
                  cur        <= win;
                  sdram_rnw  <= rnw_nxt[win];
                  sdram_addr <= addr_nxt[win];
                  sdram_din  <= din_nxt[win];
                  sdram_be   <= be_nxt[win];
               end
            end
            S_ISSUE: begin
               state <= S_WAIT;
               cnt   <= '0;
            end
            S_WAIT: begin
               cnt <= cnt + CW'(1);
               if (fin) begin
                  state      <= S_IDLE;
                  last_grant <= cur;
                  if (to_hit) timeout_err <= 1'b1;
                  if (sdram_rnw) dout_q[cur] <= ready_hit ? sdram_dout : 32'd0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign sdram_req  = (state == S_ISSUE);
   assign busy       = (state != S_IDLE) | (|pending);
   assign port0_done = done_q[0];
   assign port1_done = done_q[1];
   assign port2_done = done_q[2];
   assign port0_dout = dout_q[0];
   assign port1_dout = dout_q[1];
   assign port2_dout = dout_q[2];

endmodule

// File: tb/tb_sdram_ch2_arbiter.sv
// Bench for sdram_ch2_arbiter: vector table, SDRAM response model,
// and a completion scoreboard checked on every done pulse.
module tb_sdram_ch2_arbiter;

   localparam int TO = 16;

   typedef struct {
      int          port;
      logic        rnw;
      logic [26:0] addr;
      logic [31:0] din;
      logic [3:0]  be;
      int          lat;
      logic [31:0] rdata;
      logic [31:0] exp_dout;
   } vec_t;

   typedef struct {
      int          port;
      logic [31:0] dout;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        port0_req, port0_rnw, port0_done;
   logic [26:0] port0_addr;
   logic [31:0] port0_din, port0_dout;
   logic [3:0]  port0_be;
   logic        port1_req, port1_rnw, port1_done;
   logic [26:0] port1_addr;
   logic [31:0] port1_din, port1_dout;
   logic [3:0]  port1_be;
   logic        port2_req, port2_rnw, port2_done;
   logic [26:0] port2_addr;
   logic [31:0] port2_din, port2_dout;
   logic [3:0]  port2_be;
   logic        sdram_req, sdram_rnw;
   logic [26:0] sdram_addr;
   logic [31:0] sdram_din;
   logic [3:0]  sdram_be;
   logic [31:0] sdram_dout = 32'd0;
   logic        sdram_ready = 1'b0;
   logic        pause, busy, timeout_err;

   sdram_ch2_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .port0_req(port0_req), .port0_rnw(port0_rnw), .port0_addr(port0_addr),
      .port0_din(port0_din), .port0_be(port0_be), .port0_dout(port0_dout),
      .port0_done(port0_done),
      .port1_req(port1_req), .port1_rnw(port1_rnw), .port1_addr(port1_addr),
      .port1_din(port1_din), .port1_be(port1_be), .port1_dout(port1_dout),
      .port1_done(port1_done),
      .port2_req(port2_req), .port2_rnw(port2_rnw), .port2_addr(port2_addr),
      .port2_din(port2_din), .port2_be(port2_be), .port2_dout(port2_dout),
      .port2_done(port2_done),
      .sdram_req(sdram_req), .sdram_rnw(sdram_rnw), .sdram_addr(sdram_addr),
      .sdram_din(sdram_din), .sdram_be(sdram_be), .sdram_dout(sdram_dout),
      .sdram_ready(sdram_ready), .pause(pause), .busy(busy),
      .timeout_err(timeout_err)
   );

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   last_req_cyc = -100;
   exp_t sb[$];

   int          model_lat = 0;
   logic        use_fix = 1'b0;
   logic [31:0] fix_data = 32'd0;
   int          cd = 0;
   logic [26:0] m_addr = 27'd0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mdat(input logic [26:0] a);
      return {a, 5'h0} ^ 32'hC3A5_5A3C;
   endfunction

   function automatic logic done_of(input int n);
      case (n)
         0: return port0_done;
         1: return port1_done;
         default: return port2_done;
      endcase
   endfunction

   function automatic logic [31:0] dout_of(input int n);
      case (n)
         0: return port0_dout;
         1: return port1_dout;
         default: return port2_dout;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      port0_req = 1'b0;
      port1_req = 1'b0;
      port2_req = 1'b0;
   endtask

   task automatic drive_req(input int n, input logic rnw, input logic [26:0] a,
                            input logic [31:0] d, input logic [3:0] be);
      case (n)
         0: begin port0_req = 1'b1; port0_rnw = rnw; port0_addr = a;
                  port0_din = d; port0_be = be; end
         1: begin port1_req = 1'b1; port1_rnw = rnw; port1_addr = a;
                  port1_din = d; port1_be = be; end
         default: begin port2_req = 1'b1; port2_rnw = rnw; port2_addr = a;
                  port2_din = d; port2_be = be; end
      endcase
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_reqs();
      tick();
      tick();
      reset = 1'b0;
   endtask

   // SDRAM side: answers each sdram_req after model_lat cycles (0 = never).
   always begin
      @(posedge clk);
      #1;
      sdram_ready = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            sdram_ready = 1'b1;
            sdram_dout  = use_fix ? fix_data : mdat(m_addr);
         end
      end
      if (sdram_req && model_lat > 0) begin
         cd     = model_lat;
         m_addr = sdram_addr;
      end
   end

   // Monitor: issue spacing and in-order completion scoreboard.
   always begin
      @(posedge clk);
      #1;
      if (sdram_req) begin
         chk("issue_gap", 64'((cyc - last_req_cyc) >= 3), 64'd1);
         last_req_cyc = cyc;
      end
      for (int n = 0; n < 3; n++) begin
         if (done_of(n)) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL sb_unexpected_done port=%0d actual=done required=none", n);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_port", 64'(n), 64'(e.port));
               chk("sb_dout", 64'(dout_of(n)), 64'(e.dout));
            end
         end
      end
   end

   task automatic run_row(input vec_t v);
      int          c1, pulses;
      logic        stable, got;
      logic [63:0] f0;
      model_lat = v.lat;
      use_fix   = 1'b1;
      fix_data  = v.rdata;
      sb.push_back('{v.port, v.exp_dout});
      drive_req(v.port, v.rnw, v.addr, v.din, v.be);
      tick();
      clear_reqs();
      chk("row_latency", 64'(sdram_req), 64'd1);
      f0 = {sdram_rnw, sdram_addr, sdram_din, sdram_be};
      chk("row_fields", f0, {v.rnw, v.addr, v.din, v.be});
      c1 = cyc;
      pulses = 0;
      stable = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         if ({sdram_rnw, sdram_addr, sdram_din, sdram_be} != f0) stable = 1'b0;
         if (sdram_req) pulses++;
         if (done_of(v.port)) got = 1'b1;
      end
      chk("row_done_seen", 64'(got), 64'd1);
      chk("row_done_cycle", 64'(cyc - c1), 64'(v.lat + 1));
      chk("row_stable", {32'(pulses), 31'd0, stable}, 64'd1);
      chk("row_busy_after", 64'(busy), 64'd0);
      tick();
      chk("row_done_pulse", 64'(done_of(v.port)), 64'd0);
   endtask

   task automatic burst(input int o0, input int o1, input int o2,
                        input logic [26:0] base);
      int ord[3];
      ord[0] = o0;
      ord[1] = o1;
      ord[2] = o2;
      model_lat = 2;
      use_fix   = 1'b0;
      for (int k = 0; k < 3; k++)
         sb.push_back('{ord[k], mdat(base + 27'(ord[k] * 16))});
      for (int n = 0; n < 3; n++)
         drive_req(n, 1'b1, base + 27'(n * 16), 32'd0, 4'hF);
      tick();
      clear_reqs();
      for (int i = 0; i < 80 && sb.size() != 0; i++) tick();
      chk("burst_drain", 64'(sb.size()), 64'd0);
      sb.delete();
      tick();
   endtask

   vec_t vt[8];

   initial begin
      int   pulses, dones;
      logic got;
      vt[0] = '{1, 1'b1, 27'h0001000, 32'h0,        4'hF, 6, 32'hDEADBEEF, 32'hDEADBEEF};
      vt[1] = '{0, 1'b1, 27'h0000040, 32'h0,        4'hF, 2, 32'hA5A50001, 32'hA5A50001};
      vt[2] = '{0, 1'b0, 27'h7FFFFFC, 32'h11223344, 4'b0101, 4, 32'hFFFFFFFF, 32'hA5A50001};
      vt[3] = '{2, 1'b1, 27'h7FFFFFF, 32'h0,        4'hF, 1, 32'h12345678, 32'h12345678};
      vt[4] = '{2, 1'b0, 27'h0000000, 32'hCAFEF00D, 4'hF, 3, 32'h0,        32'h12345678};
      vt[5] = '{1, 1'b0, 27'h0000010, 32'h55AA55AA, 4'b1000, 1, 32'h0,     32'hDEADBEEF};
      vt[6] = '{0, 1'b1, 27'h0000300, 32'h0,        4'hF, 2, 32'h00C0FFEE, 32'h00C0FFEE};
      vt[7] = '{1, 1'b1, 27'h0000800, 32'h0,        4'hF, 2, 32'h600DF00D, 32'h600DF00D};

      pause = 1'b0;
      port0_rnw = 1'b1; port0_addr = '0; port0_din = '0; port0_be = '0;
      port1_rnw = 1'b1; port1_addr = '0; port1_din = '0; port1_be = '0;
      port2_rnw = 1'b1; port2_addr = '0; port2_din = '0; port2_be = '0;
      do_reset();

      chk("rst_ctrl", 64'({sdram_req, sdram_rnw, busy, timeout_err,
                           port0_done, port1_done, port2_done}), 64'b0100000);
      chk("rst_addr", 64'(sdram_addr), 64'd0);
      chk("rst_din_be", 64'({sdram_din, sdram_be}), 64'd0);
      chk("rst_dout01", {port0_dout, port1_dout}, 64'd0);
      chk("rst_dout2", 64'(port2_dout), 64'd0);

      for (int i = 0; i < 6; i++) run_row(vt[i]);

      do_reset();
      burst(0, 1, 2, 27'h0000100);
      burst(0, 1, 2, 27'h0000200);
      run_row(vt[6]);
      burst(1, 2, 0, 27'h0000400);

      // Timeout: model never answers.
      chk("to_err_clear", 64'(timeout_err), 64'd0);
      model_lat = 0;
      sb.push_back('{1, 32'd0});
      drive_req(1, 1'b1, 27'h00ABCDE, 32'd0, 4'hF);
      tick();
      clear_reqs();
      chk("to_issue", 64'(sdram_req), 64'd1);
      begin
         int c1;
         c1 = cyc;
         got = 1'b0;
         for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (port1_done) got = 1'b1;
         end
         chk("to_done_seen", 64'(got), 64'd1);
         chk("to_done_cycle", 64'(cyc - c1), 64'(TO + 1));
      end
      chk("to_dout_zero", 64'(port1_dout), 64'd0);
      chk("to_err_set", 64'(timeout_err), 64'd1);
      tick();
      run_row(vt[7]);
      chk("to_err_sticky", 64'(timeout_err), 64'd1);

      // Pause holds a pending request; duplicate request is ignored.
      pause = 1'b1;
      model_lat = 3;
      use_fix = 1'b1;
      fix_data = 32'h0BADCAFE;
      sb.push_back('{2, 32'h0BADCAFE});
      drive_req(2, 1'b1, 27'h0000123, 32'd0, 4'hF);
      tick();
      clear_reqs();
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         if (sdram_req) pulses++;
         if (i == 2) drive_req(2, 1'b1, 27'h0004567, 32'd0, 4'hF);
         else clear_reqs();
         tick();
      end
      clear_reqs();
      chk("pause_blocks", 64'(pulses), 64'd0);
      chk("pause_busy", 64'(busy), 64'd1);
      pause = 1'b0;
      tick();
      chk("pause_release", 64'(sdram_req), 64'd1);
      chk("pause_keep_addr", 64'(sdram_addr), 64'h123);
      pause = 1'b1;
      dones = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (port2_done) dones++;
      end
      chk("pause_one_done", 64'(dones), 64'd1);
      pause = 1'b0;
      tick();
      chk("pause_idle_busy", 64'(busy), 64'd0);

      // Re-request on the same edge as completion.
      model_lat = 3;
      use_fix = 1'b0;
      sb.push_back('{0, mdat(27'h0000A00)});
      sb.push_back('{0, mdat(27'h0000B00)});
      drive_req(0, 1'b1, 27'h0000A00, 32'd0, 4'hF);
      tick();
      clear_reqs();
      chk("b2b_issue", 64'(sdram_req), 64'd1);
      tick();
      tick();
      tick();
      drive_req(0, 1'b1, 27'h0000B00, 32'd0, 4'hF);
      tick();
      clear_reqs();
      chk("b2b_first_done", 64'(port0_done), 64'd1);
      chk("b2b_repending", 64'(busy), 64'd1);
      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      chk("b2b_drain", 64'(sb.size()), 64'd0);
      sb.delete();
      tick();
      tick();

      // Reset mid-WAIT, req during reset, then a late ready.
      model_lat = 10;
      use_fix = 1'b1;
      fix_data = 32'hFFFF0000;
      drive_req(0, 1'b1, 27'h0000C00, 32'd0, 4'hF);
      tick();
      clear_reqs();
      chk("rw_issue", 64'(sdram_req), 64'd1);
      tick();
      tick();
      tick();
      reset = 1'b1;
      drive_req(1, 1'b1, 27'h0000D00, 32'd0, 4'hF);
      tick();
      reset = 1'b0;
      clear_reqs();
      chk("rw_busy", 64'(busy), 64'd0);
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         if (port0_done || port1_done || port2_done) dones++;
         tick();
      end
      chk("rw_no_done", 64'(dones), 64'd0);
      chk("rw_idle", 64'({busy, sdram_req}), 64'd0);
      chk("rw_err_cleared", 64'(timeout_err), 64'd0);
      chk("rw_dout0", 64'(port0_dout), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sdram_ch2_arbiter.md
SDRAM_CH2_ARBITER -- requirements
Module: sdram_ch2_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles spent in WAIT for sdram_ready before forced completion.
REQ-002 SHALL have port: clk  in  1  clock.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset; one clock, all logic in clk domain.
REQ-004 SHALL have ports, per requester N in {0,1,2}: portN_req  in  1  single-cycle request pulse.
REQ-005 SHALL have per-N ports: portN_rnw  in  1  (1=read, 0=write); portN_addr  in  27  byte address; portN_din  in  32  write data; portN_be  in  4  byte enables.
REQ-006 SHALL have per-N ports: portN_dout  out  32  read data; portN_done  out  1  single-cycle completion pulse.
REQ-007 SHALL have ports: sdram_req  out  1; sdram_rnw  out  1; sdram_addr  out  27; sdram_din  out  32; sdram_be  out  4 -- drive the SDRAM controller's 32-bit channel.
REQ-008 SHALL have ports: sdram_dout  in  32; sdram_ready  in  1  single-cycle completion pulse from SDRAM controller.
REQ-009 SHALL have ports: pause  in  1  blocks new issues (e.g. forced refresh); busy  out  1  high when not IDLE or any request pending; timeout_err  out  1  sticky.

Function
REQ-010 SHALL latch rnw/addr/din/be and set pendingN on the clock edge where portN_req=1 and pendingN=0.
REQ-011 SHALL ignore portN_req while pendingN=1 (no overwrite of latched fields, no extra done).
REQ-012 SHALL implement states IDLE, ISSUE, WAIT.
REQ-013 IDLE: if pause=0 and any pending (including a req sampled this edge), SHALL select winner round-robin starting at (last_grant+1) mod 3, load sdram_* fields from winner's latch, go to ISSUE.
REQ-014 SHALL drive sdram_req=1 only in ISSUE, for exactly one cycle; ISSUE always goes to WAIT.
REQ-015 Latency: portN_req high in cycle 0 with arbiter IDLE, no other pending, pause=0 -> sdram_req high in cycle 1.
REQ-016 SHALL hold sdram_rnw/addr/din/be stable from ISSUE until leaving WAIT.
REQ-017 WAIT: on sdram_ready=1, SHALL, at that edge, capture sdram_dout into portN_dout if read (write leaves portN_dout unchanged), pulse portN_done high in the next cycle, clear pendingN, set last_grant=N, go IDLE.
REQ-018 sdram_req SHALL be low for at least 2 cycles between consecutive issues (WAIT exit, IDLE) so SDRAM-side rising-edge detection sees every request.
REQ-019 WAIT counter SHALL start at 0 on entry, increment each cycle; if it reaches TIMEOUT without sdram_ready, SHALL complete as REQ-017 with portN_dout=0 for reads and set timeout_err.
REQ-020 sdram_ready while in IDLE or ISSUE SHALL be ignored.
REQ-021 portN_req for the port currently in WAIT, arriving same edge as sdram_ready, SHALL be accepted as a new pending request (pendingN cleared then set).
REQ-022 pause rising during ISSUE/WAIT SHALL NOT abort the active transfer; it only blocks the next IDLE selection.
REQ-023 busy SHALL = (state != IDLE) | pending0 | pending1 | pending2.

Reset
REQ-024 On reset: state=IDLE, all pending=0, last_grant=2 (port0 wins first), sdram_req=0, sdram_rnw=1, sdram_addr/din=0, sdram_be=0, all portN_done=0, all portN_dout=0, timeout_err=0, WAIT counter=0.
REQ-025 Reset asserted mid-WAIT SHALL drop the transfer with no done pulse; a subsequent sdram_ready SHALL be ignored per REQ-020.
REQ-026 portN_req coinciding with reset SHALL be discarded.

Verification
REQ-027 Single read: port1 read addr 0x0001000; model returns 0xDEADBEEF 6 cycles after sdram_req -> sdram_req high cycle 1 only, port1_dout=0xDEADBEEF, port1_done one cycle, busy low after.
REQ-028 Contention: port0,1,2 req same cycle after reset -> service order 0,1,2; next all-three burst after last_grant=2 -> order 0,1,2 again; with last_grant=0 -> order 1,2,0.
REQ-029 Write with be=4'b0101, din=0x11223344 -> sdram_rnw=0, sdram_be=0101, sdram_din=0x11223344 stable through WAIT; port0_dout unchanged.
REQ-030 Timeout: TIMEOUT=16, model never asserts ready -> done after 16 WAIT cycles, dout=0, timeout_err=1 sticky until reset.
REQ-031 pause=1 with port2 pending -> no sdram_req; pause drop -> sdram_req next cycle; duplicate port2_req while pending -> exactly one done.
REQ-032 Reset in WAIT then late sdram_ready -> no done pulse, state IDLE, busy=0.
